// File: rtl/pipeline_stage_reg_pkg.sv
// Shared types for the pipeline stage register: skid-buffer state encoding and
// an example packed stage payload with its bubble encoding.
package pipeline_stage_reg_pkg;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

    // ORI $0,$0,0 : writes nothing, so it is a safe bubble for the decode stage
    localparam if_id_t IF_ID_NOP = '{instr: 32'h3400_0000, pc_plus4: 32'h0000_0000};

endpackage

// File: rtl/pipeline_stage_reg_if.sv
// Valid/ready payload channel between pipeline stages.
interface pipeline_stage_reg_if #(
    parameter int unsigned DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_stage_reg_skid_buf.sv
// Skid entry and occupancy state for the two-entry mode; in_ready comes straight
// from a flop so the upstream ready path is cut.
module pipeline_skid_buf
    import pipeline_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_flush,
    input  logic              i_acc,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output skid_state_e       o_state,
    output logic [DATA_W-1:0] o_skid_data,
    output logic              o_ready
);

    skid_state_e       r_state;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= SK_EMPTY;
            r_skid_data <= NOP_VALUE;
            r_ready     <= 1'b1;
        end else if (i_flush) begin
            r_state     <= SK_EMPTY;
            r_skid_data <= NOP_VALUE;
            r_ready     <= 1'b1;
        end else begin
            case (r_state)
                SK_EMPTY: begin
                    if (i_acc) r_state <= SK_ONE;
                end
                SK_ONE: begin
                    if (i_acc && !i_pop) begin
                        r_skid_data <= i_data;
                        r_state     <= SK_FULL;
                        r_ready     <= 1'b0;
                    end else if (i_pop && !i_acc) begin
                        r_state <= SK_EMPTY;
                    end
                end
                SK_FULL: begin
                    if (i_pop) begin
                        r_skid_data <= NOP_VALUE;
                        r_state     <= SK_ONE;
                        r_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= SK_EMPTY;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_state     = r_state;
    assign o_skid_data = r_skid_data;
    assign o_ready     = r_ready;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush to
// bubble, optional skid buffer and a saturating stall counter.
module pipeline_stage_reg
    import pipeline_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int unsigned       SKID      = 0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 i_flush,
    pipeline_stage_reg_if.slave  s_in,
    pipeline_stage_reg_if.master m_out,
    input  logic                 i_clr_stats,
    output logic [CNT_W-1:0]     o_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_ready;
    logic              w_acc;
    logic              w_pop;
    logic              w_m_load;
    logic              w_m_valid_nxt;
    logic [DATA_W-1:0] w_m_data_nxt;

    assign w_acc = s_in.valid & w_in_ready;
    assign w_pop = r_out_valid & m_out.ready;

    generate
        if (SKID != 0) begin : g_skid
            skid_state_e       w_state;
            logic [DATA_W-1:0] w_skid_data;

            pipeline_skid_buf #(
                .DATA_W   (DATA_W),
                .NOP_VALUE(NOP_VALUE)
            ) u_skid (
                .CLK        (CLK),
                .nRST       (nRST),
                .i_flush    (i_flush),
                .i_acc      (w_acc),
                .i_pop      (w_pop),
                .i_data     (s_in.data),
                .o_state    (w_state),
                .o_skid_data(w_skid_data),
                .o_ready    (w_in_ready)
            );

            // M is always the older entry; S only refills M when M drains
            always_comb begin
                w_m_load      = 1'b0;
                w_m_valid_nxt = r_out_valid;
                w_m_data_nxt  = r_out_data;
                case (w_state)
                    SK_EMPTY: begin
                        if (w_acc) begin
                            w_m_load      = 1'b1;
                            w_m_valid_nxt = 1'b1;
                            w_m_data_nxt  = s_in.data;
                        end
                    end
                    SK_ONE: begin
                        if (w_acc && w_pop) begin
                            w_m_load      = 1'b1;
                            w_m_valid_nxt = 1'b1;
                            w_m_data_nxt  = s_in.data;
                        end else if (w_pop && !w_acc) begin
                            w_m_load      = 1'b1;
                            w_m_valid_nxt = 1'b0;
                            w_m_data_nxt  = NOP_VALUE;
                        end
                    end
                    SK_FULL: begin
                        if (w_pop) begin
                            w_m_load      = 1'b1;
                            w_m_valid_nxt = 1'b1;
                            w_m_data_nxt  = w_skid_data;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin : g_single
            assign w_in_ready = ~r_out_valid | m_out.ready;

            always_comb begin
                w_m_load      = 1'b0;
                w_m_valid_nxt = r_out_valid;
                w_m_data_nxt  = r_out_data;
                if (w_acc) begin
                    w_m_load      = 1'b1;
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = s_in.data;
                end else if (w_pop) begin
                    w_m_load      = 1'b1;
                    w_m_valid_nxt = 1'b0;
                    w_m_data_nxt  = NOP_VALUE;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_out_valid <= 1'b0;
            r_out_data  <= NOP_VALUE;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= NOP_VALUE;
        end else if (w_m_load) begin
            r_out_valid <= w_m_valid_nxt;
            r_out_data  <= w_m_data_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (i_clr_stats) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !m_out.ready && !i_flush && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign s_in.ready   = w_in_ready;
    assign m_out.valid  = r_out_valid;
    assign m_out.data   = r_out_data;
    assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench: u0 is the single-register variant with a 4-bit stall counter,
// u1 the skid variant with a 16-bit counter.
module tb_pipeline_stage_reg;
    import pipeline_stage_reg_pkg::*;

    localparam int unsigned       DW  = 64;
    localparam logic [DW-1:0]     NOP = IF_ID_NOP;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;
    logic        flush0 = 1'b0, flush1 = 1'b0;
    logic        clr0 = 1'b0, clr1 = 1'b0;
    logic [3:0]  stall0;
    logic [15:0] stall1;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    pipeline_stage_reg_if #(.DATA_W(DW)) in0 ();
    pipeline_stage_reg_if #(.DATA_W(DW)) out0 ();
    pipeline_stage_reg_if #(.DATA_W(DW)) in1 ();
    pipeline_stage_reg_if #(.DATA_W(DW)) out1 ();

    pipeline_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(0), .CNT_W(4)) u0 (
        .CLK(CLK), .nRST(nRST), .i_flush(flush0), .s_in(in0), .m_out(out0),
        .i_clr_stats(clr0), .o_stall_cnt(stall0)
    );

    pipeline_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1), .CNT_W(16)) u1 (
        .CLK(CLK), .nRST(nRST), .i_flush(flush1), .s_in(in1), .m_out(out1),
        .i_clr_stats(clr1), .o_stall_cnt(stall1)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (out0.valid && out0.ready) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u0_unexpected: got %h expected nothing", out0.data);
                end else chk("u0_out", out0.data, q0.pop_front());
            end else if (!out0.valid) chk("u0_bubble", out0.data, NOP);
            if (out1.valid && out1.ready) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u1_unexpected: got %h expected nothing", out1.data);
                end else chk("u1_out", out1.data, q1.pop_front());
            end else if (!out1.valid) chk("u1_bubble", out1.data, NOP);
        end
    end

    task automatic send0(input logic [DW-1:0] d, input bit exp);
        int n = 0;
        in0.valid = 1'b1;
        in0.data  = d;
        @(negedge CLK);
        while (in0.ready !== 1'b1 && n < 100) begin n++; @(negedge CLK); end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL u0_send_timeout: got no in_ready expected in_ready=1 for %h", d);
        end
        @(posedge CLK); #1;
        if (exp) q0.push_back(d);
    endtask

    task automatic send1(input logic [DW-1:0] d, input bit exp);
        int n = 0;
        in1.valid = 1'b1;
        in1.data  = d;
        @(negedge CLK);
        while (in1.ready !== 1'b1 && n < 100) begin n++; @(negedge CLK); end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL u1_send_timeout: got no in_ready expected in_ready=1 for %h", d);
        end
        @(posedge CLK); #1;
        if (exp) q1.push_back(d);
    endtask

    initial begin
        in0.valid = 1'b0; in0.data = '0; out0.ready = 1'b1;
        in1.valid = 1'b0; in1.data = '0; out1.ready = 1'b1;

        // reset held for three cycles, released between edges
        repeat (3) @(posedge CLK);
        #2 nRST = 1'b1;
        @(negedge CLK);
        chk("rst_u1_valid", 64'(out1.valid), 64'd0);
        chk("rst_u1_data", out1.data, NOP);
        chk("rst_u1_in_ready", 64'(in1.ready), 64'd1);
        chk("rst_u1_stall", 64'(stall1), 64'd0);
        chk("rst_u0_in_ready", 64'(in0.ready), 64'd1);
        chk("rst_u0_stall", 64'(stall0), 64'd0);
        @(posedge CLK); #1;

        // single-register streaming, one-cycle latency
        for (int i = 1; i <= 4; i++) begin
            send0(64'(i), 1'b1);
            chk("u0_stream_data", out0.data, 64'(i));
            chk("u0_stream_in_ready", 64'(in0.ready), 64'd1);
        end
        in0.valid = 1'b0;
        repeat (2) @(posedge CLK); #1;

        // single-register flush discards a concurrent accept
        in0.valid = 1'b1; in0.data = 64'h55; flush0 = 1'b1;
        @(posedge CLK); #1;
        flush0 = 1'b0; in0.valid = 1'b0;
        chk("u0_flush_valid", 64'(out0.valid), 64'd0);
        repeat (2) @(posedge CLK); #1;

        // skid back-pressure: A stalls three cycles, B sits in S, C waits
        out1.ready = 1'b0;
        fork
            begin
                send1(64'hA, 1'b1);
                send1(64'hB, 1'b1);
                send1(64'hC, 1'b1);
                in1.valid = 1'b0;
            end
            begin
                int n = 0;
                @(negedge CLK);
                while (out1.valid !== 1'b1 && n < 100) begin n++; @(negedge CLK); end
                if (n >= 100) begin
                    checks++; errors++;
                    $display("FAIL u1_bp_timeout: got out_valid=0 expected 1");
                end
                @(posedge CLK);
                @(negedge CLK);
                chk("u1_bp_in_ready_low", 64'(in1.ready), 64'd0);
                @(posedge CLK);
                @(posedge CLK); #1;
                out1.ready = 1'b1;
            end
        join
        repeat (4) @(posedge CLK); #1;
        chk("u1_bp_stall_cnt", 64'(stall1), 64'd3);
        chk("u1_bp_drained", 64'(q1.size()), 64'd0);

        // skid streaming at full rate
        for (int i = 0; i < 3; i++) begin
            send1(64'h40 + 64'(i), 1'b1);
            chk("u1_stream_data", out1.data, 64'h40 + 64'(i));
        end
        in1.valid = 1'b0;
        repeat (2) @(posedge CLK); #1;

        // flush while FULL, with a new word offered at the same time
        out1.ready = 1'b0;
        send1(64'h10, 1'b0);
        send1(64'h11, 1'b0);
        in1.valid = 1'b1; in1.data = 64'h12; flush1 = 1'b1;
        @(posedge CLK); #1;
        flush1 = 1'b0; in1.valid = 1'b0;
        @(negedge CLK);
        chk("u1_flush_valid", 64'(out1.valid), 64'd0);
        chk("u1_flush_data", out1.data, NOP);
        chk("u1_flush_in_ready", 64'(in1.ready), 64'd1);
        @(posedge CLK); #1;
        out1.ready = 1'b1;
        repeat (3) @(posedge CLK); #1;

        // 4-bit counter saturation and clear
        clr0 = 1'b1;
        @(posedge CLK); #1;
        clr0 = 1'b0;
        out0.ready = 1'b0;
        send0(64'h77, 1'b1);
        in0.valid = 1'b0;
        repeat (14) @(posedge CLK);
        @(negedge CLK);
        chk("u0_stall_14", 64'(stall0), 64'd14);
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("u0_stall_sat", 64'(stall0), 64'd15);
        @(posedge CLK); #1;
        clr0 = 1'b1;
        @(posedge CLK); #1;
        clr0 = 1'b0;
        @(negedge CLK);
        chk("u0_stall_clr", 64'(stall0), 64'd0);
        @(posedge CLK); #1;
        out0.ready = 1'b1;
        repeat (2) @(posedge CLK); #1;

        // asynchronous reset while FULL
        out1.ready = 1'b0;
        send1(64'h20, 1'b0);
        send1(64'h21, 1'b0);
        in1.valid = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("arst_u1_valid", 64'(out1.valid), 64'd0);
        chk("arst_u1_data", out1.data, NOP);
        chk("arst_u1_stall", 64'(stall1), 64'd0);
        repeat (2) @(posedge CLK);
        #3 nRST = 1'b1;
        @(posedge CLK); #1;
        out1.ready = 1'b1;
        chk("arst_u1_in_ready", 64'(in1.ready), 64'd1);
        send1(64'h30, 1'b1);
        chk("arst_u1_first", out1.data, 64'h30);
        in1.valid = 1'b0;
        repeat (3) @(posedge CLK); #1;

        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_reg.md
Name: pipeline_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the five-stage MIPS core; replaces per-stage hand-written latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed payload word with a valid/ready handshake instead of a bare enable.
- Adds synchronous flush-to-bubble, an optional two-entry skid mode for full throughput with a registered ready, and a saturating stall counter for performance debug.

Parameters:
- DATA_W, 64: payload width in bits (packed stage struct).
- NOP_VALUE, '0 (DATA_W bits): payload driven while holding a bubble; the wrapper passes the packed encoding of ORI/OR with RegWr=0, memWr=0, halt=0.
- SKID, 0: 0 = single register, combinational ready; 1 = two-entry skid buffer, registered ready.
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all held entries (branch/jump resolve, exception).
- in_valid  in  1  upstream stage presents a valid payload.
- in_ready  out  1  this stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream payload is valid.
- out_ready  in  1  downstream consumes the payload this cycle (0 = hazard or memory stall).
- out_data  out  DATA_W  downstream payload; NOP_VALUE whenever out_valid=0.
- clr_stats  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset is asynchronous on nRST low:
  - out_valid=0, out_data=NOP_VALUE, skid entry empty, stall_cnt=0.
  - in_ready=1 once reset is released (for SKID=0 it is combinational, so in_ready=1 whenever out_valid=0).
  - Reset mid-transfer discards everything; no partial payload survives.
- Transfer definitions:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (pop) = out_valid & out_ready.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On acc: out_data<=in_data and out_valid<=1; latency is 1 cycle.
  - On pop without acc: out_valid<=0 and out_data<=NOP_VALUE.
  - Otherwise the register holds.
  - Throughput is 1/cycle when out_ready=1.
- SKID=1 uses a main register M (drives out_*) and a skid register S, with states EMPTY, ONE, FULL:
  - in_ready is a flop, equal to (state!=FULL).
  - EMPTY: acc -> M<=in_data, go to ONE.
  - ONE, acc & pop -> M<=in_data, stay in ONE.
  - ONE, acc & ~pop -> S<=in_data, go to FULL.
  - ONE, pop & ~acc -> M<=NOP_VALUE, go to EMPTY.
  - FULL, pop -> M<=S, S<=NOP_VALUE, go to ONE. acc is impossible in FULL because in_ready=0.
  - Order is preserved: M is always older than S.
  - Latency is 1 cycle when EMPTY; no bubble is inserted under back-pressure that lasts a single cycle.
- flush has highest priority after reset:
  - Next cycle: out_valid=0, out_data=NOP_VALUE, S emptied, state=EMPTY, in_ready=1.
  - An acc in the same cycle as flush is discarded.
  - A pop in the same cycle as flush still completes; downstream owns the flush decision for the item it consumes.
- out_data is never X. Bubbles always carry NOP_VALUE, so downstream RegWr/memWr are 0 on bubbles.
- stall_cnt:
  - Increments when out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_stats has priority over increment, so the value is 0 on the next cycle.
  - Unaffected by flush.
- in_valid must stay asserted with stable in_data until acc. The bench asserts this protocol; the block does not check it.

Decomposition:
- cpu_types_pkg gains:
  - packed stage structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t);
  - a localparam NOP payload per struct built from ORI/OR with control bits cleared.
- pipeline_stage_reg is fully type-agnostic over a DATA_W vector. Per-stage wrappers cast the struct to and from the vector.
- One natural sub-module is pipeline_skid_buf, which holds the S register plus the EMPTY/ONE/FULL state. It is instantiated under generate only when SKID=1.

Test Plan:
- Reset with SKID=1, DATA_W=64: hold nRST low 3 cycles, then release -> out_valid=0, out_data=NOP_VALUE, in_ready=1, stall_cnt=0.
- Streaming with SKID=0: in_data=1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 one cycle later, out_valid high for 4 cycles, in_ready constantly 1.
- Back-pressure with SKID=1:
  - Stimulus: stream 0xA,0xB,0xC; drop out_ready for 3 cycles after 0xA appears.
  - Response: in_ready falls after 0xB enters S; no loss or duplication; output order is A,B,C; stall_cnt=3.
- Flush with SKID=1, state FULL (M=0x10, S=0x11): assert flush together with in_valid (0x12) -> next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1, and 0x12 is never output.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; pulse clr_stats -> stall_cnt=0 next cycle.
- Asynchronous reset while FULL with SKID=1: pull nRST low between clock edges -> out_valid drops immediately; after release the first output is only new data.
